// File: rtl/gpio_debounce.sv
// gpio_debounce -- debouncer for active-low GPIO buttons.
//
// Each raw pin is synchronized by two flops. A shared prescaler produces a
// 1 ms tick. A channel's debounced level changes only after the synchronized
// input has differed from it for DEBOUNCE_MS consecutive ticks. A one-cycle
// press or release pulse follows each change, in the next cycle.
//
// Optional feature: define GPIO_DEBOUNCE_IRQ_EN to build the per-channel
// press-interrupt pending register and the irq output. Without the macro,
// irq is tied to 0 and irq_mask/irq_clr are ignored.
//
// Ports:
//   clk          system clock; all logic runs on its rising edge
//   RST          asynchronous, active-high reset
//   btn_raw      raw button pins, active-low, asynchronous
//   btn_state    debounced level (1 = released)
//   btn_press    one-cycle pulse after a debounced 1->0
//   btn_release  one-cycle pulse after a debounced 0->1
//   irq_mask     per-channel press-interrupt enable
//   irq_clr      write-one-to-clear for pending bits
//   irq          OR of pending bits, registered

module gpio_debounce_chan #(
    parameter int DEBOUNCE_MS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic din,
    output logic state,
    output logic press,
    output logic rel
);
    logic [3:0] cnt;
    logic       state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            state   <= 1'b1;
            state_d <= 1'b1;
            press   <= 1'b0;
            rel     <= 1'b0;
        end else begin
            // state_d holds the previous level. The edge pulses therefore
            // appear in the cycle after state changes.
            state_d <= state;
            press   <= state_d & ~state;
            rel     <= ~state_d & state;
            if (din == state) begin
                cnt <= '0;                 // also gives glitch rejection
            end else if (tick) begin
                if (cnt == 4'(DEBOUNCE_MS - 1)) begin
                    state <= din;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end
endmodule

module gpio_debounce #(
    parameter int NUM_INPUTS  = 6,
    parameter int CLOCK_FREQ  = 25125000,
    parameter int DEBOUNCE_MS = 8
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [NUM_INPUTS-1:0] btn_raw,
    output logic [NUM_INPUTS-1:0] btn_state,
    output logic [NUM_INPUTS-1:0] btn_press,
    output logic [NUM_INPUTS-1:0] btn_release,
    input  logic [NUM_INPUTS-1:0] irq_mask,
    input  logic [NUM_INPUTS-1:0] irq_clr,
    output logic                  irq
);
    localparam int TICK_DIV = CLOCK_FREQ / 1000;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [NUM_INPUTS-1:0] sync1, sync2;
    logic [PW-1:0]         presc;
    logic                  tick;

    // Two-flop synchronizer. It resets to released (all ones).
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge RST) begin
        if (RST)       presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
        gpio_debounce_chan #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_ch (
            .clk  (clk),
            .rst  (RST),
            .tick (tick),
            .din  (sync2[i]),
            .state(btn_state[i]),
            .press(btn_press[i]),
            .rel  (btn_release[i])
        );
    end

`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic [NUM_INPUTS-1:0] pending;

    // A set wins over a clear that arrives in the same cycle.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pending <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= (pending & ~irq_clr) | (btn_press & irq_mask);
            irq     <= |pending;
        end
    end
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{irq_mask, irq_clr};
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_gpio_debounce.sv
module tb_gpio_debounce;
    localparam int N    = 6;
    localparam int CF   = 8000;
    localparam int DEB  = 4;
    localparam int TDIV = CF / 1000;

    logic         clk = 1'b0;
    logic         RST = 1'b0;
    logic [N-1:0] btn_raw  = '1;
    logic [N-1:0] irq_mask = '0;
    logic [N-1:0] irq_clr  = '0;
    logic [N-1:0] btn_state, btn_press, btn_release;
    logic         irq;

    gpio_debounce #(.NUM_INPUTS(N), .CLOCK_FREQ(CF), .DEBOUNCE_MS(DEB)) dut (
        .clk(clk), .RST(RST), .btn_raw(btn_raw), .btn_state(btn_state),
        .btn_press(btn_press), .btn_release(btn_release),
        .irq_mask(irq_mask), .irq_clr(irq_clr), .irq(irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. It works from the rules: the pin is seen two clocks
    // late. The 1 ms tick fires on every TDIV-th clock after reset. A level is
    // accepted once the input has disagreed with it for DEB ticks in a row.
    // Each change produces a pulse one clock later.
    logic [N-1:0] h1, h2, m_st, m_press, m_rel, pp, pr, m_pend;
    logic         m_irq;
    int           ticks[N];
    int           cyc;

    task automatic model_step();
        bit tk;
        if (RST) begin
            h1 = '1; h2 = '1; m_st = '1; m_press = '0; m_rel = '0;
            pp = '0; pr = '0; m_pend = '0; m_irq = 1'b0; cyc = 0;
            for (int c = 0; c < N; c++) ticks[c] = 0;
        end else begin
            tk  = (cyc % TDIV) == TDIV - 1;
            cyc = cyc + 1;
`ifdef GPIO_DEBOUNCE_IRQ_EN
            m_irq  = |m_pend;
            m_pend = (m_pend & ~irq_clr) | (m_press & irq_mask);
`endif
            m_press = pp; m_rel = pr; pp = '0; pr = '0;
            for (int c = 0; c < N; c++) begin
                if (h2[c] == m_st[c]) ticks[c] = 0;
                else if (tk) begin
                    ticks[c] = ticks[c] + 1;
                    if (ticks[c] == DEB) begin
                        m_st[c] = h2[c]; ticks[c] = 0;
                        if (h2[c]) pr[c] = 1'b1; else pp[c] = 1'b1;
                    end
                end
            end
            h2 = h1; h1 = btn_raw;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare the DUT against the model on every clock outside reset.
    initial forever begin
        @(negedge clk);
        if (!RST && $time > 20) begin
            chk("model_state",   int'(btn_state),   int'(m_st));
            chk("model_press",   int'(btn_press),   int'(m_press));
            chk("model_release", int'(btn_release), int'(m_rel));
            chk("model_irq",     int'(irq),         int'(m_irq));
        end
    end

    task automatic tk(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Wait, with a bound, for a press or release pulse on any channel in `which`.
    task automatic wait_pulse(input string name, input logic [N-1:0] which, input bit use_press);
        for (int i = 0; i < 80; i++) begin
            tk(1);
            if (((use_press ? btn_press : btn_release) & which) != '0) return;
        end
        checks++; errors++;
        $display("FAIL %s: no pulse within 80 cycles", name);
    endtask

    int n;

    initial begin
        // Reset
        #1 RST = 1'b1;
        tk(3);
        chk("reset_state",   int'(btn_state),   'h3f);
        chk("reset_press",   int'(btn_press),   0);
        chk("reset_release", int'(btn_release), 0);
        chk("reset_irq",     int'(irq),         0);
        RST = 1'b0;
        tk(5);

        // Clean press on channel 0
        btn_raw[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tk(1); n++;
            if (btn_state[0] == 1'b0) break;
        end
        chk("press_latency_in_27_35", int'(n >= 27 && n <= 35), 1);
        chk("press_others", int'(btn_state), 'h3e);
        tk(1);
        chk("press_pulse", int'(btn_press), 'h01);
        tk(1);
        chk("press_pulse_end", int'(btn_press), 0);
        btn_raw[0] = 1'b1;
        tk(45);

        // Glitch on channel 2
        btn_raw[2] = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == 20) btn_raw[2] = 1'b1;
            tk(1);
            chk("glitch_state",  int'(btn_state), 'h3f);
            chk("glitch_pulses", int'(btn_press | btn_release), 0);
        end

        // Simultaneous release of channels 4 and 5
        btn_raw[5:4] = 2'b00;
        tk(45);
        chk("both_pressed", int'(btn_state), 'h0f);
        btn_raw[5:4] = 2'b11;
        wait_pulse("rel45_wait", 6'b110000, 1'b0);
        chk("rel45_same_cycle", int'(btn_release), 'h30);
        tk(10);

        // Reset in the middle of qualification
        btn_raw[1] = 1'b0;
        tk(18);
        RST = 1'b1;
        tk(2);
        chk("midrst_state", int'(btn_state), 'h3f);
        RST = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tk(1); n++;
            if (btn_state[1] == 1'b0) break;
        end
        chk("midrst_latency", n, 32);
        btn_raw[1] = 1'b1;
        tk(45);

`ifdef GPIO_DEBOUNCE_IRQ_EN
        irq_mask = 6'b000001;
        btn_raw[0] = 1'b0;
        wait_pulse("irq_p0_wait", 6'b000001, 1'b1);
        tk(2);
        chk("irq_set", int'(irq), 1);
        btn_raw[3] = 1'b0;
        wait_pulse("irq_p3_wait", 6'b001000, 1'b1);
        btn_raw[0] = 1'b1; btn_raw[3] = 1'b1;
        tk(45);
        btn_raw[0] = 1'b0;
        wait_pulse("irq_p0b_wait", 6'b000001, 1'b1);
        irq_clr[0] = 1'b1;          // coincides with the pending set
        tk(1);
        irq_clr[0] = 1'b0;
        tk(2);
        chk("irq_set_wins", int'(irq), 1);
        irq_clr[0] = 1'b1;
        tk(1);
        irq_clr[0] = 1'b0;
        tk(1);
        chk("irq_cleared", int'(irq), 0);   // ch3 was masked, so nothing else is pending
        btn_raw[0] = 1'b1;
        tk(45);
        irq_mask = '0;
`endif

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 39) == 0) btn_raw[c] = ~btn_raw[c];
            if (i % 100 == 0) irq_mask = N'($urandom);
            irq_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            RST = (i >= 1500 && i < 1503);
            tk(1);
        end
        RST = 1'b0;
        irq_clr = '0;
        tk(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
